// File: rtl/pmp_pkg.sv
// Shared constants and channel-packing helper for the pattern-matching front end.
package pmp_pkg;

    localparam int PMP_MAX_CH     = 32;
    localparam int PMP_STATUS_W   = 32;
    localparam int PMP_DATA_W     = 64;
    localparam int PMP_CTRL_W     = 16;
    localparam int PMP_FIFO_DEPTH = 4;
    localparam int PMP_CNT_W      = 16;

    // Bit offset of channel c inside a flat vector of w-bit channel slices.
    function automatic int chan_off(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/pmp_frontend_if.sv
// Bus-side and engine-side signal bundle of the pattern-matching front end.
interface pmp_frontend_if
    import pmp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = PMP_DATA_W,
    parameter int CTRL_W = PMP_CTRL_W,
    parameter int CNT_W  = PMP_CNT_W,
    parameter int LVL_W  = $clog2(PMP_FIFO_DEPTH + 1)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*CTRL_W-1:0] in_control;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        chan_enable;
    logic [NUM_CH*DATA_W-1:0] eng_data;
    logic [NUM_CH*CTRL_W-1:0] eng_control;
    logic [NUM_CH-1:0]        eng_valid;
    logic [NUM_CH-1:0]        eng_ready;
    logic [NUM_CH-1:0]        eng_accepted;
    logic [PMP_STATUS_W-1:0]  match_status;
    logic [PMP_STATUS_W-1:0]  match_clear;
    logic [NUM_CH-1:0]        cnt_clear;
    logic [NUM_CH*CNT_W-1:0]  match_count;
    logic [NUM_CH*LVL_W-1:0]  fifo_level;

    modport master (
        output in_data, in_control, in_valid, chan_enable, eng_ready, eng_accepted,
               match_clear, cnt_clear,
        input  in_ready, eng_data, eng_control, eng_valid, match_status, match_count,
               fifo_level
    );

    modport slave (
        input  in_data, in_control, in_valid, chan_enable, eng_ready, eng_accepted,
               match_clear, cnt_clear,
        output in_ready, eng_data, eng_control, eng_valid, match_status, match_count,
               fifo_level
    );
endinterface

// File: rtl/pmp_chan_fifo.sv
// One channel: input FIFO feeding a registered engine-side output stage, with flush on disable.
module pmp_chan_fifo
    import pmp_pkg::*;
#(
    parameter int W     = PMP_DATA_W + PMP_CTRL_W,
    parameter int DEPTH = PMP_FIFO_DEPTH,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [W-1:0]     push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    assign full       = (level == LVL_W'(DEPTH));
    assign push_ready = enable && !full;
    assign push       = push_valid && push_ready;
    // The head moves into the output stage whenever that stage is idle or being taken.
    assign pop        = enable && (level != '0) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!enable) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end
endmodule

// File: rtl/pmp_frontend.sv
// Buffered multi-channel front end: per-channel FIFOs plus sticky match status and counters.
module pmp_frontend
    import pmp_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = PMP_DATA_W,
    parameter int CTRL_W     = PMP_CTRL_W,
    parameter int FIFO_DEPTH = PMP_FIFO_DEPTH,
    parameter int CNT_W      = PMP_CNT_W,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input logic           clk,
    input logic           reset,
    pmp_frontend_if.slave bus
);
    localparam int PW = DATA_W + CTRL_W;
    localparam logic [PMP_STATUS_W-1:0] CH_MASK = PMP_STATUS_W'((64'd1 << NUM_CH) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]       acc_q;
    logic [NUM_CH-1:0]       rise_q;
    logic [PMP_STATUS_W-1:0] status_q;
    logic [PMP_STATUS_W-1:0] rise_ext;
    logic [CNT_W-1:0]        cnt_q [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] out_payload;

        pmp_chan_fifo #(
            .W     (PW),
            .DEPTH (FIFO_DEPTH),
            .LVL_W (LVL_W)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .enable     (bus.chan_enable[c]),
            .push_data  ({bus.in_control[chan_off(c, CTRL_W) +: CTRL_W],
                          bus.in_data[chan_off(c, DATA_W) +: DATA_W]}),
            .push_valid (bus.in_valid[c]),
            .push_ready (bus.in_ready[c]),
            .out_data   (out_payload),
            .out_valid  (bus.eng_valid[c]),
            .out_ready  (bus.eng_ready[c]),
            .level      (bus.fifo_level[chan_off(c, LVL_W) +: LVL_W])
        );

        assign bus.eng_data[chan_off(c, DATA_W) +: DATA_W]    = out_payload[DATA_W-1:0];
        assign bus.eng_control[chan_off(c, CTRL_W) +: CTRL_W] = out_payload[PW-1:DATA_W];
        assign bus.match_count[chan_off(c, CNT_W) +: CNT_W]   = cnt_q[c];
    end

    always_comb begin
        rise_ext             = '0;
        rise_ext[NUM_CH-1:0] = rise_q;
    end

    assign bus.match_status = status_q;

    // Rises are registered once before touching status/counters, so they land one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            rise_q   <= '0;
            status_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            acc_q    <= bus.eng_accepted;
            rise_q   <= bus.eng_accepted & ~acc_q & bus.chan_enable;
            status_q <= ((status_q & ~bus.match_clear) | rise_ext) & CH_MASK;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rise_q[c]) begin
                    if (bus.cnt_clear[c]) begin
                        cnt_q[c] <= CNT_W'(1);
                    end else if (cnt_q[c] != CNT_MAX) begin
                        cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                    end
                end else if (bus.cnt_clear[c]) begin
                    cnt_q[c] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pmp_frontend.sv
// Self-checking bench for pmp_frontend: ordering scoreboard, match/counter vector table, corner sequences.
module tb_pmp_frontend;
    import pmp_pkg::*;

    localparam int NCH   = 4;
    localparam int DW    = 64;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = 2;
    localparam int LVLW  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [DW+CW-1:0] sb_q [NCH][$];

    typedef struct {
        logic [3:0] acc;
        logic [3:0] mclr;
        logic [3:0] cclr;
        logic [3:0] exp_status;
        logic [1:0] exp_cnt1;
        logic [1:0] exp_cnt3;
    } match_vec_t;

    match_vec_t vecs [21];

    pmp_frontend_if #(.NUM_CH(NCH), .DATA_W(DW), .CTRL_W(CW), .CNT_W(CNTW), .LVL_W(LVLW)) bus ();

    pmp_frontend #(
        .NUM_CH     (NCH),
        .DATA_W     (DW),
        .CTRL_W     (CW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
        return d[CW-1:0] ^ 16'hA5A5;
    endfunction

    task automatic applyStimulus(input int ch, input logic [DW-1:0] d);
        bus.in_data[ch*DW +: DW]    = d;
        bus.in_control[ch*CW +: CW] = ctrlOf(d);
        bus.in_valid[ch]            = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] engData(input int ch);
        return bus.eng_data[ch*DW +: DW];
    endfunction

    function automatic logic [LVLW-1:0] level(input int ch);
        return bus.fifo_level[ch*LVLW +: LVLW];
    endfunction

    function automatic logic [CNTW-1:0] count(input int ch);
        return bus.match_count[ch*CNTW +: CNTW];
    endfunction

    // Words enter the scoreboard on accepted pushes and must leave in order on engine transfers.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset || !bus.chan_enable[c]) begin
                sb_q[c].delete();
            end else begin
                if (bus.eng_valid[c] && bus.eng_ready[c]) begin
                    checkOutput($sformatf("sb_nonempty_ch%0d", c), 128'(sb_q[c].size() != 0), 128'd1);
                    if (sb_q[c].size() != 0) begin
                        checkOutput($sformatf("sb_word_ch%0d", c),
                                    {bus.eng_control[c*CW +: CW], bus.eng_data[c*DW +: DW]},
                                    sb_q[c].pop_front());
                    end
                end
                if (bus.in_valid[c] && bus.in_ready[c]) begin
                    sb_q[c].push_back({bus.in_control[c*CW +: CW], bus.in_data[c*DW +: DW]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got6;

        // acc, mclr, cclr, status, cnt1, cnt3
        vecs[0]  = '{4'h2, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0};
        vecs[1]  = '{4'h2, 4'h0, 4'h0, 4'h2, 2'd1, 2'd0};
        vecs[2]  = '{4'h2, 4'h0, 4'h0, 4'h2, 2'd1, 2'd0};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 4'h2, 2'd1, 2'd0};
        vecs[4]  = '{4'h2, 4'h0, 4'h0, 4'h2, 2'd1, 2'd0};
        vecs[5]  = '{4'h0, 4'h2, 4'h0, 4'h2, 2'd2, 2'd0};
        vecs[6]  = '{4'h0, 4'h2, 4'h0, 4'h0, 2'd2, 2'd0};
        vecs[7]  = '{4'h0, 4'h0, 4'h2, 4'h0, 2'd0, 2'd0};
        vecs[8]  = '{4'h8, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0};
        vecs[9]  = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd1};
        vecs[10] = '{4'h8, 4'h0, 4'h0, 4'h8, 2'd0, 2'd1};
        vecs[11] = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd2};
        vecs[12] = '{4'h8, 4'h0, 4'h0, 4'h8, 2'd0, 2'd2};
        vecs[13] = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[14] = '{4'h8, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[15] = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[16] = '{4'h8, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[17] = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[18] = '{4'h8, 4'h0, 4'h0, 4'h8, 2'd0, 2'd3};
        vecs[19] = '{4'h0, 4'h0, 4'h8, 4'h8, 2'd0, 2'd1};
        vecs[20] = '{4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 2'd1};

        bus.in_data      = '0;
        bus.in_control   = '0;
        bus.in_valid     = '0;
        bus.chan_enable  = 4'hF;
        bus.eng_ready    = '0;
        bus.eng_accepted = '0;
        bus.match_clear  = '0;
        bus.cnt_clear    = '0;

        #3;
        checkOutput("rst_eng_valid", 128'(bus.eng_valid), 128'd0);
        checkOutput("rst_fifo_level", 128'(bus.fifo_level), 128'd0);
        checkOutput("rst_match_status", 128'(bus.match_status), 128'd0);
        checkOutput("rst_match_count", 128'(bus.match_count), 128'd0);
        checkOutput("rst_in_ready", 128'(bus.in_ready), 128'hF);
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] basic order and latency on ch2");
        bus.eng_ready = 4'hF;
        applyStimulus(2, 64'h11);
        tick();
        checkOutput("lat_not_yet", 128'(bus.eng_valid), 128'd0);
        applyStimulus(2, 64'h22);
        tick();
        checkOutput("lat_valid", 128'(bus.eng_valid), 128'h4);
        checkOutput("order_w0", 128'(engData(2)), 128'h11);
        applyStimulus(2, 64'h33);
        tick();
        checkOutput("order_w1", 128'(engData(2)), 128'h22);
        bus.in_valid = '0;
        tick();
        checkOutput("order_w2", 128'(engData(2)), 128'h33);
        checkOutput("order_w2_ctrl", 128'(bus.eng_control[2*CW +: CW]), 128'(ctrlOf(64'h33)));
        tick();
        checkOutput("empty_drop_valid", 128'(bus.eng_valid), 128'd0);
        checkOutput("empty_hold_data", 128'(engData(2)), 128'h33);

        $display("[TB] backpressure and full on ch0");
        bus.eng_ready = 4'h0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 64'h100 + 64'(i));
            tick();
        end
        checkOutput("full_in_ready", 128'(bus.in_ready[0]), 128'd0);
        checkOutput("full_level", 128'(level(0)), 128'd4);
        checkOutput("full_head", 128'(engData(0)), 128'h100);
        bus.eng_ready[0] = 1'b1;
        got6 = 1'b0;
        for (int n = 0; n < 20 && !got6; n++) begin
            tick();
            if (bus.in_ready[0]) begin
                tick();
                got6 = 1'b1;
            end
        end
        bus.in_valid = '0;
        checkOutput("push6_accepted", 128'(got6), 128'd1);
        repeat (8) tick();
        checkOutput("drain_level", 128'(level(0)), 128'd0);
        checkOutput("drain_valid", 128'(bus.eng_valid), 128'd0);

        $display("[TB] match status and counter vectors");
        for (int v = 0; v < 21; v++) begin
            bus.eng_accepted = vecs[v].acc;
            bus.match_clear  = {28'h0, vecs[v].mclr};
            bus.cnt_clear    = vecs[v].cclr;
            tick();
            checkOutput($sformatf("vec%0d_status", v), 128'(bus.match_status), 128'(vecs[v].exp_status));
            checkOutput($sformatf("vec%0d_cnt1", v), 128'(count(1)), 128'(vecs[v].exp_cnt1));
            checkOutput($sformatf("vec%0d_cnt3", v), 128'(count(3)), 128'(vecs[v].exp_cnt3));
        end
        bus.eng_accepted = '0;
        bus.match_clear  = '0;
        bus.cnt_clear    = '0;

        $display("[TB] disable mid-stream on ch0");
        bus.eng_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 64'h200 + 64'(i));
            tick();
        end
        bus.in_valid = '0;
        checkOutput("dis_level_before", 128'(level(0)), 128'd3);
        bus.chan_enable[0] = 1'b0;
        tick();
        checkOutput("dis_level", 128'(level(0)), 128'd0);
        checkOutput("dis_valid", 128'(bus.eng_valid[0]), 128'd0);
        checkOutput("dis_in_ready", 128'(bus.in_ready[0]), 128'd0);
        checkOutput("dis_status_kept", 128'(bus.match_status), 128'h8);
        checkOutput("dis_count_kept", 128'(count(3)), 128'd1);
        bus.chan_enable[0] = 1'b1;
        bus.eng_ready[0]   = 1'b1;
        applyStimulus(0, 64'hAA);
        tick();
        bus.in_valid = '0;
        tick();
        checkOutput("reen_valid", 128'(bus.eng_valid[0]), 128'd1);
        checkOutput("reen_data", 128'(engData(0)), 128'hAA);
        repeat (3) tick();

        $display("[TB] async reset mid-operation");
        bus.eng_ready = 4'h0;
        bus.eng_accepted = 4'hF;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCH; c++) begin
                applyStimulus(c, 64'h300 + 64'(c * 16 + i));
            end
            tick();
        end
        bus.in_valid = '0;
        tick();
        checkOutput("busy_valid", 128'(bus.eng_valid), 128'hF);
        checkOutput("busy_status", 128'(bus.match_status), 128'hF);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", 128'(bus.eng_valid), 128'd0);
        checkOutput("arst_level", 128'(bus.fifo_level), 128'd0);
        checkOutput("arst_status", 128'(bus.match_status), 128'd0);
        checkOutput("arst_count", 128'(bus.match_count), 128'd0);
        checkOutput("arst_data", 128'(bus.eng_data), 128'd0);
        checkOutput("arst_ctrl", 128'(bus.eng_control), 128'd0);
        checkOutput("arst_in_ready", 128'(bus.in_ready), 128'hF);
        bus.eng_accepted = '0;
        tick();
        reset = 1'b0;
        bus.eng_ready = 4'hF;
        applyStimulus(1, 64'h77);
        tick();
        bus.in_valid = '0;
        checkOutput("post_rst_not_yet", 128'(bus.eng_valid), 128'd0);
        tick();
        checkOutput("post_rst_valid", 128'(bus.eng_valid), 128'h2);
        checkOutput("post_rst_data", 128'(engData(1)), 128'h77);
        repeat (3) tick();

        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("sb_drained_ch%0d", c), 128'(sb_q[c].size()), 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
